// File: rtl/subleq_ctrl_pkg.sv
// Shared definitions for the SUBLEQ run controller: FSM encoding, run status
// codes, phase geometry and the instruction stride.
package subleq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'd0,
    STAT_HALT    = 2'd1,
    STAT_TIMEOUT = 2'd2,
    STAT_ABORT   = 2'd3
  } status_t;

  // The core walks six one-hot states per instruction; phase 0 fetches operand A.
  localparam int PHASES     = 6;
  localparam int PHASE_W    = 3;
  localparam int INSN_BYTES = 12;

  localparam logic [PHASE_W-1:0] PHASE_FETCH_A = '0;
  localparam logic [PHASE_W-1:0] PHASE_LAST    = PHASE_W'(PHASES - 1);

  // Byte address of instruction number idx (three 32-bit words per instruction).
  function automatic logic [31:0] insn_addr(input logic [31:0] idx);
    return idx * 32'(INSN_BYTES);
  endfunction

endpackage

// File: rtl/subleq_ctrl_if.sv
// Host access port of the SUBLEQ controller.
//
// Handshake: the host raises host_valid with host_we/host_addr/host_wdata
// stable and holds them until it sees host_ready=1 in the same cycle; the
// access completes on that clock edge. host_ready never depends on anything
// but host_valid and controller state, so the host may not withdraw a request
// early without losing it. Reads return host_rdata with host_rvalid=1 in the
// cycle after acceptance; host_rvalid has no back-pressure.
interface subleq_ctrl_if;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_rvalid;

  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rdata, host_rvalid
  );

  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rdata, host_rvalid
  );
endinterface

// File: rtl/subleq_phase.sv
// Mod-6 phase counter that tracks the core's one-hot instruction state.
module subleq_phase
  import subleq_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               last_o
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] phase_d;

  // Next phase: clear wins over advance, wrap after the last phase.
  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;
  assign last_o  = (phase_q == PHASE_LAST);

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ run controller: owns the shared memory bus while idle (host loads
// and inspects memory), releases it to the core for a run, and ends the run
// on halt fetch, instruction budget or abort.
module subleq_ctrl
  import subleq_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = 32'hFFFF_FFFC,
  parameter logic [31:0] MAX_INSN  = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  subleq_ctrl_if.slave       host,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status,
  output logic [31:0]        insn_count,
  output logic               core_rst_n,
  output logic               cpu_en,
  inout  wire                mem_we,
  inout  wire  [31:0]        mem_addr,
  inout  wire  [31:0]        mem_data,
  output state_t             dbg_state
);

  state_t      state_q;
  status_t     status_q;
  logic [31:0] insn_count_q;
  logic [31:0] insn_count_d;
  logic        core_rst_n_q;
  logic        cpu_en_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] host_rdata_q;
  logic        host_rvalid_q;

  logic [PHASE_W-1:0] phase;
  logic               phase_last;

  logic host_acc;
  logic host_wr;
  logic host_rd;
  logic start_ok;
  logic halt_hit;
  logic timeout_hit;

  // Phase is parked at 0 outside RUN, so every run begins on an operand-A fetch.
  subleq_phase u_phase (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != ST_RUN),
    .en_i   (state_q == ST_RUN),
    .phase_o(phase),
    .last_o (phase_last)
  );

  // Decode host access, start qualification and run-termination conditions.
  always_comb begin
    host_acc     = (state_q == ST_IDLE) && host.host_valid;
    host_wr      = host_acc && host.host_we;
    host_rd      = host_acc && !host.host_we;
    // A pending host access takes priority over start in the same cycle.
    start_ok     = (state_q == ST_IDLE) && start && !host.host_valid;
    insn_count_d = insn_count_q + 32'd1;
    halt_hit     = (phase == PHASE_FETCH_A) && (mem_addr >= HALT_ADDR);
    timeout_hit  = phase_last && (MAX_INSN != 32'd0) && (insn_count_d == MAX_INSN);
  end

  // Controller drives the bus whenever the core does not own it.
  assign mem_we   = !cpu_en_q ? host_wr         : 1'bz;
  assign mem_addr = !cpu_en_q ? host.host_addr  : 32'bz;
  assign mem_data = (!cpu_en_q && host_wr) ? host.host_wdata : 32'bz;

  // Run FSM with registered outputs, plus host read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      status_q      <= STAT_NONE;
      insn_count_q  <= '0;
      core_rst_n_q  <= 1'b0;
      cpu_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      host_rvalid_q <= host_rd;
      if (host_rd) begin
        host_rdata_q <= mem_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q      <= ST_RUN;
            status_q     <= STAT_NONE;
            insn_count_q <= '0;
            core_rst_n_q <= 1'b1;
            cpu_en_q     <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (phase_last) begin
            insn_count_q <= insn_count_d;
          end
          if (abort || halt_hit || timeout_hit) begin
            state_q      <= ST_STOP;
            core_rst_n_q <= 1'b0;
            cpu_en_q     <= 1'b0;
            done_q       <= 1'b1;
            if (abort) begin
              status_q <= STAT_ABORT;
            end else if (halt_hit) begin
              status_q <= STAT_HALT;
            end else begin
              status_q <= STAT_TIMEOUT;
            end
          end
        end
        ST_STOP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          core_rst_n_q <= 1'b0;
          cpu_en_q     <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Reset reaches the core in the same cycle, not one clock later.
  assign core_rst_n       = core_rst_n_q && !rst;
  assign cpu_en           = cpu_en_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign status           = status_q;
  assign insn_count       = insn_count_q;
  assign dbg_state        = state_q;
  assign host.host_ready  = host_acc;
  assign host.host_rdata  = host_rdata_q;
  assign host.host_rvalid = host_rvalid_q;

endmodule

// File: doc/subleq_ctrl.md
SUBLEQ_CTRL -- requirements
Module: subleq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  HALT_ADDR  32'hFFFF_FFFC  fetch address at or above which the program is halted (unsigned compare)
  MAX_INSN   32'd0          instruction budget per run; 0 = unlimited
REQ-002 Ports (name  direction  width  meaning), one per line:
  clk          in     1   clock
  rst          in     1   reset
  host_valid   in     1   host access request
  host_ready   out    1   access accepted this cycle
  host_we      in     1   1 = write, 0 = read
  host_addr    in     32  byte address
  host_wdata   in     32  write data
  host_rdata   out    32  read data
  host_rvalid  out    1   host_rdata valid
  start        in     1   begin run
  abort        in     1   stop run
  busy         out    1   run in progress
  done         out    1   one-cycle end-of-run pulse
  status       out    2   0 none, 1 halt, 2 timeout, 3 abort
  insn_count   out    32  instructions retired in current/last run
  core_rst_n   out    1   active-low reset to core
  cpu_en       out    1   core owns memory bus
  mem_we       inout  1   shared bus write strobe
  mem_addr     inout  32  shared bus address
  mem_data     inout  32  shared bus data
REQ-003 One clock; reset is synchronous and active-high: clock port clk, reset port rst.

Function
REQ-004 FSM states: IDLE, RUN, STOP; out of reset the FSM SHALL be in IDLE.
REQ-005 IDLE: core_rst_n=0, cpu_en=0, busy=0; controller drives mem_we/mem_addr/mem_data.
REQ-006 IDLE host access: host_ready = host_valid, combinationally; a write drives mem_we=1, mem_addr=host_addr, mem_data=host_wdata for that cycle.
REQ-007 IDLE host read: mem_we=0, mem_data released (Z); mem_data sampled at the clock edge into host_rdata; host_rvalid=1 in the following cycle only.
REQ-008 In RUN/STOP: host_ready=0 (host stalls, no access lost); the controller SHALL tri-state mem_we, mem_addr and mem_data when cpu_en=1.
REQ-009 start in IDLE with host_valid=0: -> RUN next cycle; clears insn_count and status, and resets phase to 0. start outside IDLE is ignored. If start and host_valid are both high in IDLE, the host access SHALL win and start SHALL be ignored.
REQ-010 RUN: core_rst_n=1, cpu_en=1, busy=1. A 6-state phase counter (0..5, wrap 5->0) advances every RUN cycle, mirroring the core's one-hot state. Phase 0 = fetch of operand A at pc.
REQ-011 Halt: in RUN at phase 0, if mem_addr >= HALT_ADDR (unsigned), -> STOP with status=1. That fetch does not count as an instruction.
REQ-012 insn_count increments at each phase-5 cycle in RUN. It wraps at 2^32.
REQ-013 Timeout: if MAX_INSN!=0, the increment that makes insn_count equal MAX_INSN -> STOP with status=2.
REQ-014 abort in RUN -> STOP with status=3. If abort coincides with a halt or timeout condition, abort wins. abort in IDLE is ignored.
REQ-015 STOP lasts exactly one cycle: core_rst_n=0, cpu_en=0, busy=1, done=1; then -> IDLE. status and insn_count hold until the next start.
REQ-016 The instruction stride is 12 bytes (3 words); the controller never modifies core memory during RUN.

Reset
REQ-017 On rst: state=IDLE, core_rst_n=0, cpu_en=0, busy=0, done=0, status=0, insn_count=0, phase=0, host_rvalid=0, host_rdata=0.
REQ-018 If rst is asserted mid-RUN, the core SHALL be held in reset in the same cycle; no done pulse is produced.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, the status codes, PHASES=6 and INSN_BYTES=12.
REQ-020 One sub-module, subleq_phase (mod-6 counter with clear/enable and a last-phase flag), SHALL be instantiated; the remaining logic is flat.

Verification
REQ-021 Host writes 0x10 to address 0x0 -> mem_we=1, mem_addr=0x0, mem_data=0x10 that cycle. A read of 0x0 -> host_rvalid next cycle with host_rdata=0x10.
REQ-022 Program branching to 0xFFFF_FFFC after 3 instructions, start -> busy, then STOP with done=1, status=1, insn_count=3; IDLE the next cycle.
REQ-023 MAX_INSN=5 with an infinite loop -> STOP with status=2 and insn_count=5, on the phase-5 cycle of instruction 5 plus one.
REQ-024 abort asserted in RUN phase 2 -> core_rst_n=0 and cpu_en=0 next cycle, status=3, done=1.
REQ-025 host_valid held during RUN -> host_ready=0 until IDLE, then the access completes.
REQ-026 rst pulse mid-RUN -> all outputs at reset values next cycle, done stays 0.
